// File: rtl/simon_game_ctrl_if.sv
// Core-facing bundle of the Simon game controller.
// master: the controller (drives coreReset / playerNum / playerPressed).
// slave : the Simon core (drives its turn / number / pressed / game-over status).
interface simon_game_ctrl_if;
    logic       simonTurn;
    logic [1:0] simonNum;
    logic       simonPressed;
    logic       gameOver;
    logic       coreReset;
    logic [1:0] playerNum;
    logic       playerPressed;

    modport master (
        input  simonTurn, simonNum, simonPressed, gameOver,
        output coreReset, playerNum, playerPressed
    );

    modport slave (
        output simonTurn, simonNum, simonPressed, gameOver,
        input  coreReset, playerNum, playerPressed
    );
endinterface

// File: rtl/simon_game_ctrl.sv
// Simon game controller: synchronizes and debounces the start and colour buttons,
// sequences IDLE/ARM/PLAY/OVER, forwards clean single presses to the Simon core,
// keeps the score and best score, and drives the lamps.
// Optional build macro SIMON_ATTRACT_EN adds a rotating one-hot lamp pattern in IDLE.
module simon_game_ctrl #(
    parameter int DEBOUNCE = 3,
    parameter int BLINK    = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               btn,
    simon_game_ctrl_if.master        core,
    output logic [3:0]               led,
    output logic [3:0]               score,
    output logic [3:0]               highScore,
    output logic [1:0]               phase
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] PLAY = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int BCW = (BLINK > 1) ? $clog2(BLINK + 1) : 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE - 1);
    localparam logic [BCW-1:0] BL_LAST = BCW'(BLINK - 1);

    // Bit 0 is start, bits 4:1 are the colour buttons.
    logic [4:0]     raw;
    logic [4:0]     sync_a;
    logic [4:0]     sync_b;
    logic [4:0]     db;
    logic [4:0]     db_prev;
    logic [DCW-1:0] db_cnt [5];

    logic [4:0]     rise;
    logic           start_rise;
    logic [3:0]     held;
    logic           press_ok;
    logic [1:0]     press_idx;

    logic           turn_prev;
    logic           blink_on;
    logic [BCW-1:0] blink_cnt;

    assign raw        = {btn, start};
    assign rise       = db & ~db_prev;
    assign start_rise = rise[0];
    assign held       = db[4:1];
    // A press counts only when exactly one debounced colour is high and it just rose.
    assign press_ok   = (held != 4'b0000) && ((held & (held - 4'd1)) == 4'b0000)
                        && ((rise[4:1] & held) != 4'b0000);

    // Two-flop synchronizer, then a per-bit counter that accepts a new level after DEBOUNCE equal samples.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync_a  <= '0;
            sync_b  <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            db_prev <= db;
            for (int i = 0; i < 5; i++) begin
                if (sync_b[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Encode the single held colour into its index.
    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        press_idx = 2'd0;
        case (held)
            4'b0010: press_idx = 2'd1;
            4'b0100: press_idx = 2'd2;
            4'b1000: press_idx = 2'd3;
            default: press_idx = 2'd0;
        endcase
    end

    // Game sequencer: phase, core reset, score keeping, press strobe and OVER blink timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase              <= IDLE;
            core.coreReset     <= 1'b1;
            core.playerPressed <= 1'b0;
            core.playerNum     <= 2'd0;
            score              <= 4'd0;
            highScore          <= 4'd0;
            turn_prev          <= 1'b0;
            blink_on           <= 1'b0;
            blink_cnt          <= '0;
        end else begin
            core.playerPressed <= 1'b0;
            turn_prev          <= core.simonTurn;
            case (phase)
                IDLE: begin
                    if (start_rise) phase <= ARM;
                end
                ARM: begin
                    score          <= 4'd0;
                    turn_prev      <= 1'b1;
                    phase          <= PLAY;
                    core.coreReset <= 1'b0;
                end
                PLAY: begin
                    if (core.gameOver) begin
                        phase     <= OVER;
                        blink_on  <= 1'b1;
                        blink_cnt <= '0;
                        if (score > highScore) highScore <= score;
                    end else begin
                        if (core.simonTurn && !turn_prev && score != 4'd15)
                            score <= score + 4'd1;
                        if (!core.simonTurn && press_ok) begin
                            core.playerPressed <= 1'b1;
                            core.playerNum     <= press_idx;
                        end
                    end
                end
                default: begin // OVER
                    if (start_rise) begin
                        phase          <= ARM;
                        core.coreReset <= 1'b1;
                    end else if (blink_cnt == BL_LAST) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SIMON_ATTRACT_EN
    logic [BCW-1:0] att_cnt;
    logic [3:0]     att_led;

    // Attract pattern: one-hot lamp stepping every BLINK cycles while idle, cleared elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            att_cnt <= '0;
            att_led <= 4'b0000;
        end else if (phase != IDLE) begin
            att_cnt <= '0;
            att_led <= 4'b0000;
        end else if (att_cnt == BL_LAST) begin
            att_cnt <= '0;
            att_led <= (att_led == 4'b0000 || att_led[3]) ? 4'b0001 : {att_led[2:0], 1'b0};
        end else begin
            att_cnt <= att_cnt + 1'b1;
        end
    end
`endif

    // Lamp drive selected by phase; PLAY follows the core or the player live.
    always_comb begin
        led = 4'b0000;
        case (phase)
            IDLE: begin
`ifdef SIMON_ATTRACT_EN
                led = att_led;
`else
                led = 4'b0000;
`endif
            end
            PLAY: begin
                if (core.simonTurn)
                    led = core.simonPressed ? (4'b0001 << core.simonNum) : 4'b0000;
                else
                    led = held;
            end
            OVER:    led = blink_on ? 4'b1111 : 4'b0000;
            default: led = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl: randomized button / core activity
// compared every cycle against a behavioural model built from the game rules.
module tb_simon_game_ctrl;
    localparam int DEBOUNCE = 3;
    localparam int BLINK    = 15;
    localparam int IDLE = 0, ARM = 1, PLAY = 2, OVER = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] led, score, highScore;
    logic [1:0] phase;

    simon_game_ctrl_if bus ();

    simon_game_ctrl #(.DEBOUNCE(DEBOUNCE), .BLINK(BLINK)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .core      (bus.master),
        .led       (led),
        .score     (score),
        .highScore (highScore),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_raw[k]: raw {btn,start} seen k edges ago (0 = latest edge).
    logic [4:0] m_raw [0:DEBOUNCE+1];
    logic [4:0] m_db, m_db_last;
    int         m_phase, m_score, m_high, m_pnum, m_over_cyc, m_idle_cyc;
    bit         m_pp, m_turn_prev;

    function automatic void model_reset();
        for (int k = 0; k <= DEBOUNCE + 1; k++) m_raw[k] = '0;
        m_db = '0; m_db_last = '0;
        m_phase = IDLE; m_score = 0; m_high = 0; m_pnum = 0;
        m_over_cyc = 0; m_idle_cyc = 0; m_pp = 0; m_turn_prev = 0;
    endfunction

    function automatic void model_step();
        logic [4:0] rise;
        logic [3:0] hold;
        int         nxt;
        bit         same;
        rise = m_db & ~m_db_last;
        hold = m_db[4:1];
        nxt  = m_phase;
        m_pp = 0;
        case (m_phase)
            IDLE: begin
                m_idle_cyc++;
                if (rise[0]) nxt = ARM;
            end
            ARM: begin
                m_score = 0;
                nxt = PLAY;
            end
            PLAY: begin
                if (bus.gameOver) begin
                    if (m_score > m_high) m_high = m_score;
                    nxt = OVER;
                    m_over_cyc = 0;
                end else begin
                    if (bus.simonTurn && !m_turn_prev && m_score < 15) m_score++;
                    if (!bus.simonTurn && $countones(hold) == 1 && (rise[4:1] & hold) != 0) begin
                        m_pp = 1;
                        for (int i = 0; i < 4; i++) if (hold[i]) m_pnum = i;
                    end
                end
            end
            default: begin
                if (rise[0]) nxt = ARM;
                else m_over_cyc++;
            end
        endcase
        m_turn_prev = (m_phase == ARM) ? 1'b1 : bus.simonTurn;
        m_phase = nxt;
        // Input history; a debounced level changes once DEBOUNCE synchronized samples agree.
        for (int k = DEBOUNCE + 1; k > 0; k--) m_raw[k] = m_raw[k-1];
        m_raw[0] = {btn, start};
        m_db_last = m_db;
        for (int b = 0; b < 5; b++) begin
            same = 1;
            for (int k = 2; k <= DEBOUNCE + 1; k++)
                if (m_raw[k][b] != m_raw[2][b]) same = 0;
            if (same) m_db[b] = m_raw[2][b];
        end
    endfunction

    function automatic logic [3:0] exp_led();
        logic [3:0] v;
        v = 4'b0000;
        case (m_phase)
            IDLE: begin
`ifdef SIMON_ATTRACT_EN
                if (m_idle_cyc >= BLINK) v = 4'b0001 << (((m_idle_cyc / BLINK) - 1) % 4);
`endif
            end
            PLAY: begin
                if (bus.simonTurn) v = bus.simonPressed ? (4'b0001 << bus.simonNum) : 4'b0000;
                else v = m_db[4:1];
            end
            OVER: v = (((m_over_cyc / BLINK) % 2) == 0) ? 4'b1111 : 4'b0000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("phase", phase, m_phase);
            check("coreReset", bus.coreReset, (m_phase == IDLE || m_phase == ARM));
            check("playerPressed", bus.playerPressed, m_pp);
            check("playerNum", bus.playerNum, m_pnum);
            check("score", score, m_score);
            check("highScore", highScore, m_high);
            check("led", led, exp_led());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_phase", phase, IDLE);
        check("rst_coreReset", bus.coreReset, 1);
        check("rst_playerPressed", bus.playerPressed, 0);
        check("rst_playerNum", bus.playerNum, 0);
        check("rst_score", score, 0);
        check("rst_highScore", highScore, 0);
        check("rst_led", led, 0);
        tick(3);
        reset = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick(6);
        check("arm_after_start", phase, ARM);
        tick(1);
        check("play_after_arm", phase, PLAY);
        check("play_coreReset", bus.coreReset, 0);
        check("play_score", score, 0);
        start = 1'b0;
        tick(6);
    endtask

    task automatic simon_turns(input int n);
        for (int i = 0; i < n; i++) begin
            bus.simonTurn = 1'b1;
            tick(2);
            bus.simonTurn = 1'b0;
            tick(2);
        end
    endtask

    initial begin
        int kind;
        logic [3:0] pat;
        bus.simonTurn = 1'b0; bus.simonNum = 2'd0; bus.simonPressed = 1'b0; bus.gameOver = 1'b0;
        #1;
        apply_reset();
        tick(70);

        // Game 1
        start_game();

        // Exact press latency: btn 0100 sampled from edge t, strobe only after edge t+5.
        btn = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("lat_pp", bus.playerPressed, (k == 5));
            if (k == 5) check("lat_num", bus.playerNum, 2);
        end
        btn = 4'b0000;
        tick(8);

        // Randomized play episodes
        for (int ep = 0; ep < 80; ep++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1: begin
                    btn = 4'b0001 << $urandom_range(0, 3);
                    tick($urandom_range(1, 8));
                    btn = 4'b0000;
                    tick($urandom_range(4, 8));
                end
                2: begin
                    do pat = 4'($urandom_range(0, 15)); while ($countones(pat) < 2);
                    btn = pat;
                    tick($urandom_range(1, 8));
                    btn = 4'b0000;
                    tick($urandom_range(4, 8));
                end
                3: begin
                    bus.simonTurn = 1'b1;
                    repeat ($urandom_range(1, 4)) begin
                        bus.simonNum     = 2'($urandom_range(0, 3));
                        bus.simonPressed = 1'($urandom_range(0, 1));
                        btn              = 4'($urandom_range(0, 15));
                        tick($urandom_range(1, 6));
                    end
                    bus.simonTurn = 1'b0; bus.simonPressed = 1'b0; btn = 4'b0000;
                    tick($urandom_range(4, 8));
                end
                default: begin
                    start = 1'b1;
                    tick($urandom_range(1, 6));
                    start = 1'b0;
                    tick(7);
                end
            endcase
        end

        // Saturation and end of game 1
        simon_turns(16);
        check("score_saturated", score, 15);
        bus.gameOver = 1'b1;
        tick(1);
        bus.gameOver = 1'b0;
        check("over_phase", phase, OVER);
        check("over_high", highScore, 15);
        check("over_led_entry", led, 4'b1111);
        tick(70);

        // Game 2 ends at score 3; start rises together with gameOver.
        start_game();
        simon_turns(3);
        check("game2_score", score, 3);
        bus.gameOver = 1'b1;
        start = 1'b1;
        tick(1);
        bus.gameOver = 1'b0;
        check("game2_over", phase, OVER);
        check("game2_high_kept", highScore, 15);
        tick(12);
        start = 1'b0;
        tick(10);

        // Game 3 abandoned by reset mid-PLAY
        simon_turns(2);
        btn = 4'b1000;
        tick(3);
        apply_reset();
        btn = 4'b0000;
        tick(20);
        check("idle_after_reset", phase, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
